// File: rtl/cvita_pkg.sv
// Shared CVITA definitions: SID field location, stamper FSM encodings,
// source-table entry layout and the header stamping helper.
package cvita_pkg;

  localparam int CVITA_SID_SRC_LSB = 16;
  localparam int CVITA_SID_SRC_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_HDR    = 2'd2,
    ST_BODY   = 2'd3
  } state_t;

  // One source-table entry: {valid, src_addr}
  typedef struct packed {
    logic        valid;
    logic [15:0] src;
  } src_entry_t;

  // Replace SID[31:16] with the programmed source address when the entry is valid
  function automatic logic [63:0] stamp_sid(input logic [63:0] hdr, input src_entry_t entry);
    logic [63:0] res;
    res = hdr;
    if (entry.valid) res[CVITA_SID_SRC_MSB:CVITA_SID_SRC_LSB] = entry.src;
    return res;
  endfunction

endpackage

// File: rtl/cvita_src_stamp_if.sv
// Stream bundle around the stamper: input CVITA beats (with source port tag)
// and output CVITA beats.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both
// high; a source holding tvalid must keep tdata/tlast stable until that transfer.
interface cvita_src_stamp_if #(
  parameter int SRC_WIDTH = 4
);
  logic [63:0]          i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [SRC_WIDTH-1:0] i_tsrc;
  logic [63:0]          o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;

  // The stamper itself
  modport slave (
    input  i_tdata, i_tlast, i_tvalid, i_tsrc, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  // Whoever feeds the stamper and drains its output
  modport master (
    output i_tdata, i_tlast, i_tvalid, i_tsrc, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/ram_2port.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle latency.
// A same-cycle write and read of one address returns the old contents.
// Contents are deliberately not reset.
module ram_2port #(
  parameter int DWIDTH = 17,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] di_a,
  input  logic              en_b,
  input  logic [AWIDTH-1:0] addr_b,
  output logic [DWIDTH-1:0] do_b
);

  logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];
  logic [DWIDTH-1:0] do_b_q;

  // Write port A and registered read port B (read-first on collision)
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= di_a;
    if (en_b) do_b_q <= mem[addr_b];
  end

  assign do_b = do_b_q;

endmodule

// File: rtl/cvita_src_stamp.sv
// Egress source stamper: looks up the crossbar source port of each CVITA packet
// and writes the programmed 16-bit return address into SID[31:16] of the header.
// Body beats pass straight through with zero latency.
module cvita_src_stamp
  import cvita_pkg::*;
#(
  parameter int SRC_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [16:0]        set_data,
  cvita_src_stamp_if.slave   strm,
  output state_t             dbg_state
);

  state_t      state_q, state_d;
  logic [63:0] hdr_q, hdr_d;
  logic        last_q, last_d;
  logic [16:0] rd_data;
  logic        rd_en;
  logic        unused_set_addr;

  // Only the low SRC_WIDTH index bits select an entry
  assign unused_set_addr = ^set_addr;

  // Lookup is launched only when a header is taken in idle, so the entry
  // stays frozen for the rest of the packet even if the table is rewritten.
  assign rd_en = (state_q == ST_IDLE) && strm.i_tvalid;

  ram_2port #(
    .DWIDTH (17),
    .AWIDTH (SRC_WIDTH)
  ) u_src_tbl (
    .clk    (clk),
    .we_a   (set_stb),
    .addr_a (set_addr[SRC_WIDTH-1:0]),
    .di_a   (set_data),
    .en_b   (rd_en),
    .addr_b (strm.i_tsrc),
    .do_b   (rd_data)
  );

  // Next-state, header capture and in-place SID stamping
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (strm.i_tvalid) begin
          hdr_d   = strm.i_tdata;
          last_d  = strm.i_tlast;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hdr_d   = stamp_sid(hdr_q, src_entry_t'(rd_data));
        state_d = ST_HDR;
      end
      ST_HDR: begin
        if (strm.o_tready) state_d = last_q ? ST_IDLE : ST_BODY;
      end
      ST_BODY: begin
        if (strm.i_tvalid && strm.o_tready && strm.i_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and header registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      last_q  <= last_d;
    end
  end

  // Output mux: stamped header from the register, body straight through
  always_comb begin
    strm.o_tdata  = hdr_q;
    strm.o_tlast  = last_q;
    strm.o_tvalid = 1'b0;
    strm.i_tready = 1'b0;
    case (state_q)
      ST_IDLE:   strm.i_tready = 1'b1;
      ST_HDR:    strm.o_tvalid = 1'b1;
      ST_BODY: begin
        strm.o_tdata  = strm.i_tdata;
        strm.o_tlast  = strm.i_tlast;
        strm.o_tvalid = strm.i_tvalid;
        strm.i_tready = strm.o_tready;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_cvita_src_stamp.sv
// Bench for cvita_src_stamp: directed scenarios plus 1000 random packets with
// random backpressure and concurrent table writes, checked against a packet-level
// reference model of the source table and stamping rule.
module tb_cvita_src_stamp;
  import cvita_pkg::*;

  localparam int SW = 4;
  localparam int NENT = 2 ** SW;

  logic        clk;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [16:0] set_data;
  state_t      dbg_state;

  cvita_src_stamp_if #(.SRC_WIDTH(SW)) bus ();

  cvita_src_stamp #(.SRC_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .strm      (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bp_mode  = 0;   // 0: always ready, 1: random, 2: hold header 10 cycles

  // Reference model state
  logic        tbl_v [NENT];
  logic [15:0] tbl_s [NENT];
  logic [64:0] exp_q [$];
  logic [64:0] out_log [$];
  int          hdr_cyc_q [$];
  bit          in_pkt     = 0;
  int          hdr_age    = 99;
  bit          prev_stall = 0;
  logic [64:0] prev_beat;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected header: SID source field overwritten only for a valid entry
  function automatic logic [63:0] m_stamp(input logic [63:0] hdr, input logic v, input logic [15:0] src);
    if (v) return (hdr & ~64'h0000_0000_FFFF_0000) | ({48'd0, src} << 16);
    return hdr;
  endfunction

  task automatic abort(input string why);
    $display("FAIL %s: bound expired", why);
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "bench aborted");
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Sampled on the falling edge: the handshakes seen here are the ones the
  // next rising edge will complete.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      in_pkt     = 0;
      hdr_age    = 99;
      prev_stall = 0;
    end else begin
      if (hdr_age < 10) hdr_age++;
      if (hdr_age == 1) check("hdr_latency_n1", {64'd0, bus.o_tvalid}, 65'd0);
      if (hdr_age == 2) check("hdr_latency_n2", {64'd0, bus.o_tvalid}, 65'd1);
      if (prev_stall) begin
        check("stall_valid", {64'd0, bus.o_tvalid}, 65'd1);
        check("stall_hold", {bus.o_tlast, bus.o_tdata}, prev_beat);
      end
      if (bus.i_tvalid && bus.i_tready) begin
        if (!in_pkt) begin
          hdr_cyc_q.push_back(cyc);
          hdr_age = 0;
          exp_q.push_back({bus.i_tlast,
                           m_stamp(bus.i_tdata, tbl_v[bus.i_tsrc], tbl_s[bus.i_tsrc])});
        end else begin
          exp_q.push_back({bus.i_tlast, bus.i_tdata});
        end
        in_pkt = !bus.i_tlast;
      end
      if (bus.o_tvalid && bus.o_tready) begin
        out_log.push_back({bus.o_tlast, bus.o_tdata});
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: got %h expected none", {bus.o_tlast, bus.o_tdata});
        end else begin
          check("beat", {bus.o_tlast, bus.o_tdata}, exp_q.pop_front());
        end
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_beat  = {bus.o_tlast, bus.o_tdata};
    end
    // Table writes land after any same-edge lookup (old value wins)
    if (set_stb) begin
      tbl_v[set_addr[SW-1:0]] = set_data[16];
      tbl_s[set_addr[SW-1:0]] = set_data[15:0];
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    bus.o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: bus.o_tready = ($urandom_range(0, 99) < 65);
        2: begin
          if (dbg_state == ST_HDR && hold_cnt < 10) begin
            bus.o_tready = 1'b0;
            hold_cnt++;
          end else begin
            bus.o_tready = 1'b1;
            if (dbg_state != ST_HDR) hold_cnt = 0;
          end
        end
        default: bus.o_tready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc;
    int t;
    acc = 0;
    t = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.i_tvalid && bus.i_tready;
      step();
      t++;
      if (t > 300) abort("accept_timeout");
    end
  endtask

  task automatic tbl_write(input int idx, input logic v, input logic [15:0] src);
    set_stb  = 1'b1;
    set_addr = {4'($urandom_range(0, 15)), 4'(idx)};
    set_data = {v, src};
    step();
    set_stb  = 1'b0;
  endtask

  task automatic send_pkt(input int src, input logic [63:0] hdr, input int nbeats,
                          input bit gaps, input bit no_last);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
        bus.i_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) step();
      end
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = (b == 0) ? hdr : {$urandom, $urandom};
      bus.i_tlast  = (b == nbeats - 1) && !no_last;
      bus.i_tsrc   = (b == 0) ? SW'(src) : SW'($urandom_range(0, NENT - 1));
      wait_accept();
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || in_pkt || dbg_state != ST_IDLE) begin
      step();
      t++;
      if (t > 500) abort("drain_timeout");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit done;
    rst = 1'b1;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tsrc   = '0;
    for (int i = 0; i < NENT; i++) begin
      tbl_v[i] = 1'b0;
      tbl_s[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_o_tvalid", {64'd0, bus.o_tvalid}, 65'd0);
    check("rst_i_tready", {64'd0, bus.i_tready}, 65'd1);
    check("rst_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    step();

    // Program every entry so the table holds known values
    for (int i = 0; i < NENT; i++) tbl_write(i, 1'($urandom_range(0, 1)), 16'($urandom));
    tbl_write(3, 1'b1, 16'hA5C3);
    tbl_write(5, 1'b0, 16'h9999);

    // 1: valid entry stamps the SID source field
    out_log.delete();
    send_pkt(3, 64'h1234_5678_0000_0102, 3, 0, 0);
    wait_drain();
    check("t1_hdr", out_log[0], {1'b0, 64'h1234_5678_A5C3_0102});
    check("t1_beats", 65'(out_log.size()), 65'd3);
    check("t1_last", {64'd0, out_log[2][64]}, 65'd1);

    // 2: invalid entry leaves the header untouched
    out_log.delete();
    send_pkt(5, 64'hCAFE_0001_BEEF_0042, 2, 0, 0);
    wait_drain();
    check("t2_hdr", out_log[0], {1'b0, 64'hCAFE_0001_BEEF_0042});

    // 3a: header held 10 cycles under backpressure
    bp_mode = 2;
    send_pkt(3, 64'h0F0F_0F0F_0F0F_0F0F, 3, 0, 0);
    wait_drain();

    // 3b: random packets, random backpressure, concurrent table writes
    bp_mode = 1;
    done = 0;
    fork
      begin
        for (int p = 0; p < 1000; p++)
          send_pkt($urandom_range(0, NENT - 1), {$urandom, $urandom}, $urandom_range(1, 6), 1, 0);
        done = 1;
      end
      begin
        while (!done) begin
          repeat ($urandom_range(3, 30)) step();
          tbl_write($urandom_range(0, NENT - 1), 1'($urandom_range(0, 1)), 16'($urandom));
        end
      end
    join
    wait_drain();
    bp_mode = 0;
    step();
    check("t3_scoreboard_empty", 65'(exp_q.size()), 65'd0);

    // 4: write to entry 2 in the same cycle its header is accepted
    tbl_write(2, 1'b1, 16'h1111);
    step();
    out_log.delete();
    fork
      send_pkt(2, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 0);
      begin
        set_stb  = 1'b1;
        set_addr = 8'h02;
        set_data = {1'b1, 16'h2222};
        step();
        set_stb  = 1'b0;
      end
    join
    wait_drain();
    send_pkt(2, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 0);
    wait_drain();
    check("t4_old_entry", out_log[0], {1'b1, 64'hAAAA_BBBB_1111_DDDD});
    check("t4_new_entry", out_log[1], {1'b1, 64'hAAAA_BBBB_2222_DDDD});

    // 5: back-to-back single-beat packets
    tbl_write(0, 1'b1, 16'h0A0A);
    tbl_write(1, 1'b1, 16'h0B0B);
    out_log.delete();
    hdr_cyc_q.delete();
    send_pkt(0, 64'h1111_2222_3333_4444, 1, 0, 0);
    send_pkt(1, 64'h5555_6666_7777_8888, 1, 0, 0);
    wait_drain();
    check("t5_pkt0", out_log[0], {1'b1, 64'h1111_2222_0A0A_4444});
    check("t5_pkt1", out_log[1], {1'b1, 64'h5555_6666_0B0B_8888});
    check("t5_spacing", 65'(hdr_cyc_q[1] - hdr_cyc_q[0]), 65'd3);

    // 6: reset in the middle of a body
    tbl_write(7, 1'b1, 16'h7777);
    send_pkt(7, 64'h0102_0304_0506_0708, 2, 0, 1);
    check("t6_in_body", {63'd0, dbg_state}, {63'd0, ST_BODY});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_o_tvalid", {64'd0, bus.o_tvalid}, 65'd0);
    check("t6_i_tready", {64'd0, bus.i_tready}, 65'd1);
    step();
    out_log.delete();
    send_pkt(7, 64'h1020_3040_5060_7080, 2, 0, 0);
    wait_drain();
    check("t6_clean_hdr", out_log[0], {1'b0, 64'h1020_3040_7777_7080});
    check("t6_beats", 65'(out_log.size()), 65'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
